// File: rtl/typewriter_cam_drive.sv
// typewriter_cam_drive
//   Cam-shaft rotation for the typewriter mechanical model. A clutch trip
//   runs one 360-degree revolution in clocked degree steps. The shaft then
//   parks at home (0 degrees). If the clutch is still energised at the wrap,
//   the next revolution follows with no gap. The six CRCB cam contacts are
//   decoded combinationally from the shaft angle.
//
// Parameters
//   TICKS_PER_DEG : clock cycles per degree of rotation (>= 1)
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high; forces idle at home
//   clutch_mag    in   clutch magnet energised (level)
//   angle         out  [8:0] shaft angle 0..359, registered
//   running       out  shaft rotating, registered
//   cycle_done    out  one-cycle pulse after the 359->0 wrap
//   rev_count     out  [7:0] completed revolutions since reset (wraps)
//   crcb_1no_sw .. crcb_6no_sw  out  cam contacts decoded from angle
module typewriter_cam_drive #(
    parameter int TICKS_PER_DEG = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clutch_mag,
    output logic [8:0] angle,
    output logic       running,
    output logic       cycle_done,
    output logic [7:0] rev_count,
    output logic       crcb_1no_sw,
    output logic       crcb_2no_sw,
    output logic       crcb_3no_sw,
    output logic       crcb_4no_sw,
    output logic       crcb_5no_sw,
    output logic       crcb_6no_sw
);

    // Prescaler is at least one bit wide so TICKS_PER_DEG = 1 still elaborates;
    // in that case it sits at 0, which always equals PRE_LAST.
    localparam int PW = (TICKS_PER_DEG > 1) ? $clog2(TICKS_PER_DEG) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_DEG - 1);
    localparam logic [8:0]    LAST_DEG = 9'd359;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;

    // Half-open degree window [lo, hi).
    function automatic logic in_window(input logic [8:0] a,
                                       input logic [8:0] lo,
                                       input logic [8:0] hi);
        return (a >= lo) && (a < hi);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            angle      <= '0;
            prescaler  <= '0;
            running    <= 1'b0;
            cycle_done <= 1'b0;
            rev_count  <= '0;
        end else begin
            cycle_done <= 1'b0;
            if (state == IDLE) begin
                angle <= '0;
                // Trip: angle stays at 0 on this edge; the first degree
                // step comes TICKS_PER_DEG edges later.
                if (clutch_mag) begin
                    state     <= RUN;
                    running   <= 1'b1;
                    prescaler <= '0;
                end
            end else begin
                if (prescaler == PRE_LAST) begin
                    prescaler <= '0;
                    if (angle == LAST_DEG) begin
                        angle      <= '0;
                        cycle_done <= 1'b1;
                        rev_count  <= rev_count + 8'd1;
                        // The clutch is only looked at here; a trip during
                        // the revolution is neither latched nor acted on.
                        if (!clutch_mag) begin
                            state   <= IDLE;
                            running <= 1'b0;
                        end
                    end else begin
                        angle <= angle + 9'd1;
                    end
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end
        end
    end

    // Cam windows; one-degree overlaps at 50, 99 and 220, gap at 309.
    always_comb begin
        crcb_1no_sw = in_window(angle, 9'd0,   9'd51);
        crcb_2no_sw = in_window(angle, 9'd50,  9'd100);
        crcb_3no_sw = in_window(angle, 9'd99,  9'd309);
        crcb_4no_sw = in_window(angle, 9'd171, 9'd221);
        crcb_5no_sw = in_window(angle, 9'd220, 9'd300);
        crcb_6no_sw = in_window(angle, 9'd310, 9'd360);
    end

endmodule

// File: tb/tb_typewriter_cam_drive.sv
// Bench for typewriter_cam_drive: one instance at 1 tick/degree, one at 2.
module tb_typewriter_cam_drive;

    logic       clk;
    logic       reset1, reset2;
    logic       clutch1, clutch2;
    logic [8:0] a1, a2;
    logic       run1, run2, done1, done2;
    logic [7:0] rev1, rev2;
    logic [6:1] sw1, sw2;

    int total = 0;
    int bad   = 0;

    typewriter_cam_drive #(.TICKS_PER_DEG(1)) dut1 (
        .clk(clk), .reset(reset1), .clutch_mag(clutch1),
        .angle(a1), .running(run1), .cycle_done(done1), .rev_count(rev1),
        .crcb_1no_sw(sw1[1]), .crcb_2no_sw(sw1[2]), .crcb_3no_sw(sw1[3]),
        .crcb_4no_sw(sw1[4]), .crcb_5no_sw(sw1[5]), .crcb_6no_sw(sw1[6])
    );

    typewriter_cam_drive #(.TICKS_PER_DEG(2)) dut2 (
        .clk(clk), .reset(reset2), .clutch_mag(clutch2),
        .angle(a2), .running(run2), .cycle_done(done2), .rev_count(rev2),
        .crcb_1no_sw(sw2[1]), .crcb_2no_sw(sw2[2]), .crcb_3no_sw(sw2[3]),
        .crcb_4no_sw(sw2[4]), .crcb_5no_sw(sw2[5]), .crcb_6no_sw(sw2[6])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: elapsed clock edges since the revolution started.
    typedef struct {
        bit run;
        int ticks;
        int rev;
        bit done;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.run = 0; m.ticks = 0; m.rev = 0; m.done = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit clutch, int t);
        mdl_t n;
        n = m;
        n.done = 0;
        if (!m.run) begin
            if (clutch) begin
                n.run   = 1;
                n.ticks = 0;
            end
        end else begin
            n.ticks = m.ticks + 1;
            if (n.ticks == 360 * t) begin
                n.ticks = 0;
                n.done  = 1;
                n.rev   = (m.rev + 1) % 256;
                n.run   = clutch;
            end
        end
        return n;
    endfunction

    function automatic logic [24:0] mdl_out(mdl_t m, int t);
        int         a;
        logic [5:0] c;
        a    = m.ticks / t;
        c[0] = (a < 51);
        c[1] = (a >= 50)  && (a < 100);
        c[2] = (a >= 99)  && (a < 309);
        c[3] = (a >= 171) && (a < 221);
        c[4] = (a >= 220) && (a < 300);
        c[5] = (a >= 310);
        return {9'(a), m.run, m.done, 8'(m.rev), c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // One clock edge: advance both models, then compare every output #1 later.
    task automatic tick();
        @(posedge clk);
        m1 = mdl_step(m1, clutch1, 1);
        m2 = mdl_step(m2, clutch2, 2);
        #1;
        chk("model_t1", {7'd0, a1, run1, done1, rev1, sw1}, {7'd0, mdl_out(m1, 1)});
        chk("model_t2", {7'd0, a2, run2, done2, rev2, sw2}, {7'd0, mdl_out(m2, 2)});
    endtask

    typedef struct {
        int         ang;
        logic [6:1] sw;
    } cam_vec_t;

    cam_vec_t tbl [12];

    initial begin
        int idx;
        int pulses;
        bit seen;
        bit dropped;

        tbl[0]  = '{0,   6'b000001};
        tbl[1]  = '{50,  6'b000011};
        tbl[2]  = '{51,  6'b000010};
        tbl[3]  = '{99,  6'b000110};
        tbl[4]  = '{100, 6'b000100};
        tbl[5]  = '{171, 6'b001100};
        tbl[6]  = '{220, 6'b011100};
        tbl[7]  = '{221, 6'b010100};
        tbl[8]  = '{300, 6'b000100};
        tbl[9]  = '{309, 6'b000000};
        tbl[10] = '{310, 6'b100000};
        tbl[11] = '{359, 6'b100000};

        // Reset state
        reset1 = 1'b1; reset2 = 1'b1;
        clutch1 = 1'b0; clutch2 = 1'b0;
        m1 = mdl_reset(); m2 = mdl_reset();
        #1;
        chk("reset_state", {7'd0, a2, run2, done2, rev2, sw2}, {7'd0, 9'd0, 1'b0, 1'b0, 8'd0, 6'b000001});
        #11;
        reset1 = 1'b0; reset2 = 1'b0;

        // Idle for 100 cycles
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done1 || done2) seen = 1;
        end
        chk("idle_no_done", 32'(seen), 32'd0);
        chk("idle_angle", 32'(a1), 32'd0);
        chk("idle_running", 32'(run1), 32'd0);
        chk("idle_contacts", 32'(sw1), 32'b000001);

        // Single trip at 2 ticks/degree, contact sweep, trip ignored at 200
        clutch2 = 1'b1;
        tick();
        clutch2 = 1'b0;
        chk("trip_running", 32'(run2), 32'd1);
        chk("trip_angle", 32'(a2), 32'd0);
        idx = 0;
        pulses = 0;
        chk("cam_0", 32'(sw2), 32'(tbl[0].sw));
        idx = 1;
        for (int e = 1; e <= 721; e++) begin
            tick();
            if (done2) pulses++;
            if (e == 2)   chk("t2_angle_1", 32'(a2), 32'd1);
            if (e == 718) chk("t2_angle_359", 32'(a2), 32'd359);
            if (e == 720) begin
                chk("t2_wrap_angle", 32'(a2), 32'd0);
                chk("t2_wrap_done", 32'(done2), 32'd1);
                chk("t2_wrap_running", 32'(run2), 32'd0);
                chk("t2_wrap_rev", 32'(rev2), 32'd1);
            end
            if (e == 721) chk("t2_done_clear", 32'(done2), 32'd0);
            if (e < 720)  chk("t2_running_hold", 32'(run2), 32'd1);
            if ((e % 2 == 0) && idx < 12 && (e / 2 == tbl[idx].ang)) begin
                chk($sformatf("cam_%0d", tbl[idx].ang), 32'(sw2), 32'(tbl[idx].sw));
                idx++;
            end
            if (e == 400) clutch2 = 1'b1;
            if (e == 401) clutch2 = 1'b0;
        end
        chk("t2_sweep_entries", 32'(idx), 32'd12);
        chk("t2_pulse_count", 32'(pulses), 32'd1);
        repeat (10) tick();
        chk("t2_no_extra_rev", {24'd0, rev2}, 32'd1);
        chk("t2_stays_idle", 32'(run2), 32'd0);

        // Three back-to-back revolutions at 1 tick/degree
        clutch1 = 1'b1;
        tick();
        pulses = 0;
        dropped = 0;
        for (int e = 1; e <= 1085; e++) begin
            tick();
            if (done1) pulses++;
            if (e == 360 || e == 720 || e == 1080) chk($sformatf("t1_done_%0d", e), 32'(done1), 32'd1);
            if (e < 1080 && !run1) dropped = 1;
            if (e == 1000) clutch1 = 1'b0;
        end
        chk("t1_pulses", 32'(pulses), 32'd3);
        chk("t1_rev", {24'd0, rev1}, 32'd3);
        chk("t1_never_dropped", 32'(dropped), 32'd0);
        chk("t1_idle_after", 32'(run1), 32'd0);

        // Asynchronous reset at angle 137
        clutch2 = 1'b1;
        tick();
        clutch2 = 1'b0;
        repeat (274) tick();
        chk("ar_angle_before", 32'(a2), 32'd137);
        #2;
        reset2 = 1'b1;
        #1;
        m2 = mdl_reset();
        chk("ar_angle", 32'(a2), 32'd0);
        chk("ar_running", 32'(run2), 32'd0);
        chk("ar_rev", {24'd0, rev2}, 32'd0);
        #3;
        reset2 = 1'b0;
        repeat (20) tick();
        chk("ar_idle_running", 32'(run2), 32'd0);
        chk("ar_idle_angle", 32'(a2), 32'd0);

        // Randomized clutch activity against the model
        for (int i = 0; i < 3000; i++) begin
            clutch1 = ($urandom_range(0, 99) < 4);
            clutch2 = ($urandom_range(0, 99) < 3);
            if (i >= 1500 && i < 1900) clutch1 = 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
